// File: rtl/risc16_pkg.sv
// risc16_pkg: shared widths, opcodes, EX FSM encoding and ALU helpers for the 16-bit core
package risc16_pkg;
  localparam int DATA_W = 16;
  localparam int REG_ADDR_W = 4;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SLL = 4'h6;
  localparam logic [3:0] OP_SRL = 4'h7;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_LW = 4'h9;
  localparam logic [3:0] OP_SW = 4'hA;
  localparam logic [3:0] OP_LUI = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;
  typedef enum logic [1:0] {IDLE = 2'd0, MUL_BUSY = 2'd1, MUL_DONE = 2'd2} ex_state_t;
  // MUL and reserved opcodes yield 0 here; the product comes from the multiplier path
  function automatic logic [DATA_W-1:0] alu_op(input logic [3:0] op, input logic [DATA_W-1:0] a, b, imm);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR: return a | b;
      OP_XOR: return a ^ b;
      OP_SLL: return a << b[3:0];
      OP_SRL: return a >> b[3:0];
      OP_ADDI, OP_LW, OP_SW: return a + imm;
      OP_LUI: return imm << 8;
      default: return '0;
    endcase
  endfunction
  function automatic logic writes_rd(input logic [3:0] op, input logic mul_en);
    return (op >= OP_ADD && op <= OP_LW) || op == OP_LUI || (mul_en && op == OP_MUL);
  endfunction
endpackage

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle (built only with EX_MUL_EN)
`ifdef EX_MUL_EN
module ex_mul_seq
  import risc16_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic start,
  input logic abort,
  input logic [DATA_W-1:0] a,
  input logic [DATA_W-1:0] b,
  output logic busy,
  output logic done,
  output logic [DATA_W-1:0] product
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  logic [DATA_W-1:0] mcand, mplier, acc;
  logic [CNT_W-1:0] cnt;
  // done marks the final iteration; product is complete on the following cycle
  assign done = busy & (cnt == LAST);
  assign product = acc;
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt <= '0;
      acc <= '0;
      mcand <= a;
      mplier <= b;
    end else if (busy) begin
      acc <= mplier[0] ? acc + mcand : acc;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage: execute stage with registered EX/MEM outputs and valid/ready/flush control.
// Define EX_MUL_EN to enable the iterative MUL; otherwise MUL behaves as a reserved opcode.
module ex_stage
  import risc16_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic [3:0] opcode_ex,
  input logic [REG_ADDR_W-1:0] rd_ex,
  input logic [DATA_W-1:0] rs1_data_ex,
  input logic [DATA_W-1:0] rs2_data_ex,
  input logic [DATA_W-1:0] imm_val_ex,
  input logic ex_valid_in,
  input logic ex_flush,
  input logic mem_ready,
  output logic ex_stall,
  output logic [DATA_W-1:0] alu_result_mem,
  output logic [DATA_W-1:0] store_data_mem,
  output logic [REG_ADDR_W-1:0] rd_mem,
  output logic [3:0] opcode_mem,
  output logic wr_en_mem,
  output logic zero_flag_mem,
  output logic valid_mem
);
  ex_state_t state;
  logic accept, mul_busy, mul_done;
  logic [DATA_W-1:0] mul_product, mul_st, res;
  logic [REG_ADDR_W-1:0] mul_rd;
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
  assign accept = state == IDLE && ex_valid_in && opcode_ex == OP_MUL && !ex_flush;
  ex_mul_seq u_mul (
    .clk(clk), .rst(rst), .start(accept), .abort(ex_flush),
    .a(rs1_data_ex), .b(rs2_data_ex),
    .busy(mul_busy), .done(mul_done), .product(mul_product)
  );
`else
  localparam bit MUL_EN = 1'b0;
  assign accept = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_product = '0;
`endif
  assign res = alu_op(opcode_ex, rs1_data_ex, rs2_data_ex, imm_val_ex);
  assign ex_stall = !ex_flush && (!mem_ready || accept || mul_busy);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      alu_result_mem <= '0;
      store_data_mem <= '0;
      rd_mem <= '0;
      opcode_mem <= '0;
      wr_en_mem <= 1'b0;
      zero_flag_mem <= 1'b0;
      valid_mem <= 1'b0;
      mul_rd <= '0;
      mul_st <= '0;
    end else if (ex_flush) begin
      state <= IDLE;
      valid_mem <= 1'b0;
      wr_en_mem <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            state <= MUL_BUSY;
            mul_rd <= rd_ex;
            mul_st <= rs2_data_ex;
            if (mem_ready) begin
              valid_mem <= 1'b0;
              wr_en_mem <= 1'b0;
            end
          end else if (mem_ready) begin
            alu_result_mem <= res;
            zero_flag_mem <= ~|res;
            store_data_mem <= rs2_data_ex;
            rd_mem <= rd_ex;
            opcode_mem <= opcode_ex;
            wr_en_mem <= ex_valid_in && writes_rd(opcode_ex, MUL_EN);
            valid_mem <= ex_valid_in;
          end
        MUL_BUSY: begin
          if (mul_done) state <= MUL_DONE;
          if (mem_ready) begin
            valid_mem <= 1'b0;
            wr_en_mem <= 1'b0;
          end
        end
        MUL_DONE:
          if (mem_ready) begin
            state <= IDLE;
            alu_result_mem <= mul_product;
            zero_flag_mem <= ~|mul_product;
            store_data_mem <= mul_st;
            rd_mem <= mul_rd;
            opcode_mem <= OP_MUL;
            wr_en_mem <= 1'b1;
            valid_mem <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage; MUL cases follow EX_MUL_EN
module tb_ex_stage;
  import risc16_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] opcode_ex = '0, rd_ex = '0, opcode_mem, rd_mem;
  logic [15:0] rs1_data_ex = '0, rs2_data_ex = '0, imm_val_ex = '0;
  logic ex_valid_in = 1'b0, ex_flush = 1'b0, mem_ready = 1'b1;
  logic ex_stall, wr_en_mem, zero_flag_mem, valid_mem;
  logic [15:0] alu_result_mem, store_data_mem;
  int checks = 0, errors = 0;

  typedef struct packed {logic [15:0] res; logic [15:0] st; logic [3:0] rd; logic [3:0] op; logic we;} exp_t;
  typedef struct packed {logic [3:0] op; logic [3:0] rd; logic [15:0] a; logic [15:0] b; logic [15:0] imm; logic [15:0] res; logic we;} vec_t;
  exp_t sb[$];

  localparam vec_t VECS [0:15] = '{
    '{OP_ADD, 4'd3, 16'h1234, 16'h0101, 16'h0000, 16'h1335, 1'b1},
    '{OP_SUB, 4'd4, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1},
    '{OP_SW, 4'd0, 16'h0100, 16'hBEEF, 16'hFFFE, 16'h00FE, 1'b0},
    '{OP_AND, 4'd5, 16'hF0F0, 16'h0FF0, 16'h0000, 16'h00F0, 1'b1},
    '{OP_OR, 4'd6, 16'hF000, 16'h000F, 16'h0000, 16'hF00F, 1'b1},
    '{OP_XOR, 4'd7, 16'hFFFF, 16'h00FF, 16'h0000, 16'hFF00, 1'b1},
    '{OP_SLL, 4'd8, 16'h0001, 16'h0013, 16'h0000, 16'h0008, 1'b1},
    '{OP_SRL, 4'd9, 16'h8000, 16'h0014, 16'h0000, 16'h0800, 1'b1},
    '{OP_ADDI, 4'd10, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 1'b1},
    '{OP_LW, 4'd11, 16'h1000, 16'h0000, 16'h0010, 16'h1010, 1'b1},
    '{OP_LUI, 4'd12, 16'h0000, 16'h0000, 16'h00AB, 16'hAB00, 1'b1},
    '{4'hD, 4'd13, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 1'b0},
    '{OP_NOP, 4'd1, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0},
    '{4'hF, 4'd2, 16'h0F0F, 16'h0F0F, 16'h0000, 16'h0000, 1'b0},
    '{OP_ADD, 4'd14, 16'hFFFF, 16'h0002, 16'h0000, 16'h0001, 1'b1},
    '{OP_SUB, 4'd15, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 1'b1}
  };

  ex_stage dut (
    .clk(clk), .rst(rst), .opcode_ex(opcode_ex), .rd_ex(rd_ex),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_val_ex(imm_val_ex),
    .ex_valid_in(ex_valid_in), .ex_flush(ex_flush), .mem_ready(mem_ready),
    .ex_stall(ex_stall), .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem),
    .rd_mem(rd_mem), .opcode_mem(opcode_mem), .wr_en_mem(wr_en_mem),
    .zero_flag_mem(zero_flag_mem), .valid_mem(valid_mem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, rd, input logic [15:0] a, b, imm, input logic v);
    opcode_ex = op;
    rd_ex = rd;
    rs1_data_ex = a;
    rs2_data_ex = b;
    imm_val_ex = imm;
    ex_valid_in = v;
  endtask

  task automatic idle();
    drive(OP_NOP, 4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic expect_out(input logic [3:0] op, rd, input logic [15:0] b, res, input logic we);
    sb.push_back('{res, b, rd, op, we});
  endtask

  task automatic issue(input logic [3:0] op, rd, input logic [15:0] a, b, imm, res, input logic we);
    drive(op, rd, a, b, imm, 1'b1);
    expect_out(op, rd, b, res, we);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_res"}, alu_result_mem, 0);
    chk({tag, "_st"}, store_data_mem, 0);
    chk({tag, "_rd"}, rd_mem, 0);
    chk({tag, "_op"}, opcode_mem, 0);
    chk({tag, "_we"}, wr_en_mem, 0);
    chk({tag, "_zero"}, zero_flag_mem, 0);
    chk({tag, "_valid"}, valid_mem, 0);
  endtask

  // Issue a MUL at T, then count cycles until valid_mem rises (expected T+18)
  task automatic mul_run(input logic [3:0] rd, input logic [15:0] a, b, res);
    int n;
    issue(OP_MUL, rd, a, b, 16'h0, res, 1'b1);
    #1;
    chk("mul_run_stall", ex_stall, 1);
    step();
    idle();
    n = 1;
    while (!valid_mem && n < 40) begin
      step();
      n++;
    end
    chk("mul_run_latency", n, 18);
    chk("mul_run_res", alu_result_mem, res);
  endtask

  // Monitor: a transfer happens when valid_mem and mem_ready meet at the coming edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_mem && mem_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=res %h rd %h op %h required=no output", alu_result_mem, rd_mem, opcode_mem);
        end else begin
          e = sb.pop_front();
          chk("sb_res", alu_result_mem, e.res);
          chk("sb_rd", rd_mem, e.rd);
          chk("sb_op", opcode_mem, e.op);
          chk("sb_we", wr_en_mem, e.we);
          chk("sb_zero", zero_flag_mem, e.res == 16'h0);
          if (e.op == OP_SW) chk("sb_store", store_data_mem, e.st);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    step();
    check_zero("reset");
    chk("reset_stall", ex_stall, 0);
    rst = 1'b0;
    step();
    foreach (VECS[i]) begin
      issue(VECS[i].op, VECS[i].rd, VECS[i].a, VECS[i].b, VECS[i].imm, VECS[i].res, VECS[i].we);
      #1;
      chk("vec_stall", ex_stall, 0);
      step();
      chk("vec_valid", valid_mem, 1);
      chk("vec_res", alu_result_mem, VECS[i].res);
    end
    idle();
    step();
    chk("bubble_valid", valid_mem, 0);
    chk("bubble_we", wr_en_mem, 0);
    // back-pressure: EX/MEM must freeze for three cycles
    issue(OP_ADD, 4'd1, 16'h0001, 16'h0001, 16'h0, 16'h0002, 1'b1);
    step();
    issue(OP_ADD, 4'd2, 16'h0010, 16'h0010, 16'h0, 16'h0020, 1'b1);
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_stall", ex_stall, 1);
      step();
      chk("bp_frozen_res", alu_result_mem, 16'h0002);
      chk("bp_frozen_rd", rd_mem, 4'd1);
    end
    mem_ready = 1'b1;
    step();
    chk("bp_resume_res", alu_result_mem, 16'h0020);
    issue(OP_ADD, 4'd3, 16'h0100, 16'h0100, 16'h0, 16'h0200, 1'b1);
    step();
    // flush drops an instruction held under back-pressure
    drive(OP_ADD, 4'd4, 16'h0022, 16'h0011, 16'h0, 1'b1);
    step();
    chk("drop_loaded", alu_result_mem, 16'h0033);
    idle();
    mem_ready = 1'b0;
    ex_flush = 1'b1;
    #1;
    chk("flush_stall_forced", ex_stall, 0);
    step();
    ex_flush = 1'b0;
    mem_ready = 1'b1;
    chk("drop_valid", valid_mem, 0);
    chk("drop_we", wr_en_mem, 0);
`ifdef EX_MUL_EN
    issue(OP_MUL, 4'd5, 16'h0012, 16'h0034, 16'h0, 16'h03A8, 1'b1);
    #1;
    chk("mul_stall_T", ex_stall, 1);
    step();
    idle();
    #1;
    for (int k = 1; k <= 16; k++) begin
      chk("mul_busy_stall", ex_stall, 1);
      chk("mul_busy_valid", valid_mem, 0);
      if (k < 16) step();
    end
    step();
    chk("mul_done_stall", ex_stall, 0);
    chk("mul_done_valid", valid_mem, 0);
    step();
    chk("mul_out_valid", valid_mem, 1);
    chk("mul_out_res", alu_result_mem, 16'h03A8);
    mul_run(4'd9, 16'h0100, 16'h0100, 16'h0000);
    chk("mul_zero_flag", zero_flag_mem, 1);
    // flush on the fifth busy cycle
    drive(OP_MUL, 4'd6, 16'h0012, 16'h0034, 16'h0, 1'b1);
    step();
    idle();
    for (int k = 0; k < 4; k++) step();
    ex_flush = 1'b1;
    #1;
    chk("mulflush_stall_forced", ex_stall, 0);
    step();
    ex_flush = 1'b0;
    chk("mulflush_valid", valid_mem, 0);
    chk("mulflush_stall", ex_stall, 0);
    issue(OP_ADD, 4'd7, 16'h0300, 16'h0045, 16'h0, 16'h0345, 1'b1);
    step();
    chk("postflush_valid", valid_mem, 1);
    chk("postflush_res", alu_result_mem, 16'h0345);
    // reset while the multiplier is busy
    drive(OP_MUL, 4'd8, 16'h0012, 16'h0034, 16'h0, 1'b1);
    step();
    idle();
    step();
    step();
    rst = 1'b1;
    step();
    check_zero("rst_mul");
    chk("rst_mul_stall", ex_stall, 0);
    rst = 1'b0;
    step();
    mul_run(4'd8, 16'h0003, 16'h0007, 16'h0015);
`else
    issue(OP_MUL, 4'd5, 16'h0012, 16'h0034, 16'h0, 16'h0000, 1'b0);
    #1;
    chk("mul_off_stall", ex_stall, 0);
    step();
    chk("mul_off_valid", valid_mem, 1);
    chk("mul_off_res", alu_result_mem, 16'h0000);
    chk("mul_off_we", wr_en_mem, 0);
    issue(OP_ADD, 4'd7, 16'h0300, 16'h0045, 16'h0, 16'h0345, 1'b1);
    step();
    idle();
    rst = 1'b1;
    step();
    check_zero("rst_mid");
    rst = 1'b0;
`endif
    idle();
    step();
    step();
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
